// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding, default widths and direction constants for the sweep sequencer
package sweep_pkg;
  localparam int CNT_W_DEF = 22;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    H_CLR   = 4'd1,
    H_SWEEP = 4'd2,
    H_ARM   = 4'd3,
    H_RET   = 4'd4,
    V_CLR   = 4'd5,
    V_SWEEP = 4'd6,
    V_ARM   = 4'd7,
    V_RET   = 4'd8,
    FIN     = 4'd9
  } state_t;
endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: clearable up-counter with terminal-count compare, used for sweep length and return timeout
module sweep_timer
  import sweep_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  // clear has priority over counting
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_tc = r_cnt == i_last;
endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: two-axis max-search sequencer driving max_counter; RETURN_TIMEOUT_EN adds a return-phase timeout
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int SWEEP_LEN = 4000000,
  parameter int CNT_W = CNT_W_DEF
`ifdef RETURN_TIMEOUT_EN
  , parameter int TIMEOUT_LEN = 4194303
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_new_max,
  input  logic i_cnt_ru,
  output logic o_mc,
  output logic o_cnt_rst,
  output logic o_h_move,
  output logic o_v_move,
  output logic o_dir,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);
  state_t r_state, w_next;
  logic w_in_sweep, w_in_arm, w_in_ret, w_sweep_tc;
  logic w_mc, w_cnt_rst, w_h_sw, w_v_sw, w_h_ret, w_v_ret, w_dir, w_busy, w_done;
  logic r_mc, r_cnt_rst, r_h_sw, r_v_sw, r_h_ret, r_v_ret, r_dir, r_busy, r_done;
  assign w_in_sweep = (r_state == H_SWEEP) || (r_state == V_SWEEP);
  assign w_in_arm   = (r_state == H_ARM) || (r_state == V_ARM);
  assign w_in_ret   = (r_state == H_RET) || (r_state == V_RET);
  sweep_timer #(.W(CNT_W)) u_sweep (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  ((r_state == H_CLR) || (r_state == V_CLR)),
    .i_en   (w_in_sweep),
    .i_last (CNT_W'(SWEEP_LEN - 1)),
    .o_tc   (w_sweep_tc)
  );
`ifdef RETURN_TIMEOUT_EN
  logic w_tmo_tc, w_err_set, r_err;
  sweep_timer #(.W(CNT_W)) u_tmo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_in_arm),
    .i_en   (w_in_ret),
    .i_last (CNT_W'(TIMEOUT_LEN - 1)),
    .o_tc   (w_tmo_tc)
  );
`else
  logic w_unused_arm;
  assign w_unused_arm = w_in_arm;
`endif
  // next state plus the Moore outputs of that next state, so outputs leave flops aligned with the state
  always_comb begin
    w_next = r_state;
`ifdef RETURN_TIMEOUT_EN
    w_err_set = 1'b0;
`endif
    case (r_state)
      IDLE:    w_next = i_start ? H_CLR : IDLE;
      H_CLR:   w_next = H_SWEEP;
      H_SWEEP: w_next = w_sweep_tc ? H_ARM : H_SWEEP;
      H_ARM:   w_next = H_RET;
      H_RET:   w_next = i_cnt_ru ? H_RET : V_CLR;
      V_CLR:   w_next = V_SWEEP;
      V_SWEEP: w_next = w_sweep_tc ? V_ARM : V_SWEEP;
      V_ARM:   w_next = V_RET;
      V_RET:   w_next = i_cnt_ru ? V_RET : FIN;
      default: w_next = IDLE;
    endcase
`ifdef RETURN_TIMEOUT_EN
    if (w_in_ret && i_cnt_ru && w_tmo_tc) begin
      w_next = FIN;
      w_err_set = 1'b1;
    end
`endif
    w_mc      = (w_next == H_ARM) || (w_next == H_RET) || (w_next == V_ARM) || (w_next == V_RET);
    w_cnt_rst = (w_next == IDLE) || (w_next == H_CLR) || (w_next == V_CLR) || (w_next == FIN) ||
                (w_in_sweep && i_new_max);
    w_h_sw    = w_next == H_SWEEP;
    w_v_sw    = w_next == V_SWEEP;
    w_h_ret   = w_next == H_RET;
    w_v_ret   = w_next == V_RET;
    w_dir     = w_mc ? DIR_REV : DIR_FWD;
    w_busy    = w_next != IDLE;
    w_done    = w_next == FIN;
  end
  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_mc      <= 1'b0;
      r_cnt_rst <= 1'b1;
      r_h_sw    <= 1'b0;
      r_v_sw    <= 1'b0;
      r_h_ret   <= 1'b0;
      r_v_ret   <= 1'b0;
      r_dir     <= DIR_FWD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mc      <= w_mc;
      r_cnt_rst <= w_cnt_rst;
      r_h_sw    <= w_h_sw;
      r_v_sw    <= w_v_sw;
      r_h_ret   <= w_h_ret;
      r_v_ret   <= w_v_ret;
      r_dir     <= w_dir;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
`ifdef RETURN_TIMEOUT_EN
  // sticky timeout flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
  assign o_mc      = r_mc;
  assign o_cnt_rst = r_cnt_rst;
  assign o_dir     = r_dir;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  // return-phase stepping follows the registered CNT_RU of max_counter directly
  assign o_h_move  = r_h_sw | (r_h_ret & i_cnt_ru);
  assign o_v_move  = r_v_sw | (r_v_ret & i_cnt_ru);
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed bench with a behavioural max_counter; SWEEP_LEN=16, TIMEOUT_LEN=8 under RETURN_TIMEOUT_EN
module tb_sweep_sequencer;
  localparam int LEN = 16;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, new_max = 1'b0, force_ru = 1'b0;
  logic m_ru = 1'b0;
  logic [21:0] m_cnt = '0;
  logic cnt_ru, mc, cnt_rst, h_move, v_move, dir, busy, done, err;
  int total = 0, bad = 0;
  int n_busy, n_hsw, n_hret, n_vsw, n_vret, n_done, n_rst_sw, n_rst_mc, n_dir_bad, rst_idx, hs, first_h;

  always #5 clk = ~clk;
  assign cnt_ru = m_ru | force_ru;

  sweep_sequencer #(
    .SWEEP_LEN(LEN)
`ifdef RETURN_TIMEOUT_EN
    , .TIMEOUT_LEN(8)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_new_max(new_max), .i_cnt_ru(cnt_ru),
    .o_mc(mc), .o_cnt_rst(cnt_rst), .o_h_move(h_move), .o_v_move(v_move), .o_dir(dir),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  // max_counter: counts up in MC=0; in MC=1 the first cycle only raises CNT_RU, then it counts down while CNT_RU
  always @(posedge clk) begin
    if (cnt_rst) begin
      m_cnt <= '0;
      m_ru  <= 1'b0;
    end else begin
      if (!mc) m_cnt <= m_cnt + 1'b1;
      else if (m_ru && m_cnt != 0) m_cnt <= m_cnt - 1'b1;
      m_ru <= mc && (m_cnt != 0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // one START-initiated search; nm_at = H sweep index for a NEW_MAX pulse, junk = START/NEW_MAX in MC=1 cycles,
  // abort = pull RST_N low in the first V_RET cycle
  task automatic run(input int nm_at, input bit junk, input bit abort);
    n_busy = 0; n_hsw = 0; n_hret = 0; n_vsw = 0; n_vret = 0; n_done = 0;
    n_rst_sw = 0; n_rst_mc = 0; n_dir_bad = 0; rst_idx = -1; hs = 0; first_h = -1;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 400 && busy; k++) begin
      new_max = 1'b0;
      start = 1'b0;
      if (h_move && first_h < 0) first_h = k;
      if (h_move && !mc) begin
        if (cnt_rst) begin n_rst_sw++; rst_idx = hs; end
        if (hs == nm_at) new_max = 1'b1;
        hs++;
        n_hsw++;
      end
      if (v_move && !mc) begin
        n_vsw++;
        if (cnt_rst) n_rst_sw++;
      end
      if (mc && h_move) n_hret++;
      if (mc && v_move) n_vret++;
      if (mc && cnt_rst) n_rst_mc++;
      if (mc == dir) n_dir_bad++;
      if (junk && mc) begin start = 1'b1; new_max = 1'b1; end
      n_done += int'(done);
      n_busy++;
      if (abort && mc && v_move) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {mc, cnt_rst, h_move, v_move, dir, busy, done, err}, 8'h48);
        repeat (3) begin
          step;
          n_done += int'(done);
        end
        rst_n = 1'b1;
        step;
        break;
      end
      step;
    end
    new_max = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_async", {mc, cnt_rst, h_move, v_move, dir, busy, done, err}, 8'h48);
    step;
    step;
    rst_n = 1'b1;
    repeat (3) step;
    chk("idle_outputs", {mc, cnt_rst, h_move, v_move, dir, busy, done, err}, 8'h48);

    // plain search, no NEW_MAX: count 16 at arm replays as 17 CNT_RU cycles
    run(-1, 1'b0, 1'b0);
    chk("a_first_hmove", first_h, 1);
    chk("a_busy", n_busy, 73);
    chk("a_hsweep", n_hsw, 16);
    chk("a_hret", n_hret, 17);
    chk("a_vsweep", n_vsw, 16);
    chk("a_vret", n_vret, 17);
    chk("a_done", n_done, 1);
    chk("a_rst_sweep", n_rst_sw, 0);
    chk("a_rst_mc", n_rst_mc, 0);
    chk("a_dir", n_dir_bad, 0);
    chk("a_busy_after", busy, 0);

    // NEW_MAX at sweep index 10: clear at 11, count 4 at arm -> 5 return cycles
    run(10, 1'b0, 1'b0);
    chk("b_rst_idx", rst_idx, 11);
    chk("b_rst_sweep", n_rst_sw, 1);
    chk("b_hret", n_hret, 5);
    chk("b_vret", n_vret, 17);
    chk("b_busy", n_busy, 61);
    chk("b_done", n_done, 1);

    // NEW_MAX in the last sweep cycle: clear lands in H_ARM, zero-length return
    run(LEN - 1, 1'b0, 1'b0);
    chk("c_rst_mc", n_rst_mc, 1);
    chk("c_rst_sweep", n_rst_sw, 0);
    chk("c_hret", n_hret, 0);
    chk("c_vret", n_vret, 17);
    chk("c_busy", n_busy, 56);

    // START and NEW_MAX noise during ARM/RET must change nothing
    run(-1, 1'b1, 1'b0);
    chk("d_busy", n_busy, 73);
    chk("d_hret", n_hret, 17);
    chk("d_vret", n_vret, 17);
    chk("d_rst_mc", n_rst_mc, 0);
    chk("d_rst_sweep", n_rst_sw, 0);
    chk("d_done", n_done, 1);
    chk("d_busy_after", busy, 0);

    // reset during V_RET aborts without DONE, then a clean search follows
    run(-1, 1'b0, 1'b1);
    chk("e_done", n_done, 0);
    chk("e_busy_after", busy, 0);
    run(-1, 1'b0, 1'b0);
    chk("e2_busy", n_busy, 73);
    chk("e2_done", n_done, 1);
    chk("e2_hret", n_hret, 17);

`ifdef RETURN_TIMEOUT_EN
    force_ru = 1'b1;
    run(-1, 1'b0, 1'b0);
    chk("f_busy", n_busy, 27);
    chk("f_hret", n_hret, 8);
    chk("f_vsweep", n_vsw, 0);
    chk("f_done", n_done, 1);
    chk("f_err", err, 1);
    force_ru = 1'b0;
    repeat (5) step;
    chk("f_err_sticky", err, 1);
    rst_n = 1'b0;
    #1 chk("f_err_reset", err, 0);
    step;
    rst_n = 1'b1;
    step;
`else
    force_ru = 1'b1;
    n_done = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (100) begin
      step;
      n_done += int'(done);
    end
    chk("f_wait_busy", busy, 1);
    chk("f_wait_mc", mc, 1);
    chk("f_wait_hmove", h_move, 1);
    chk("f_wait_done", n_done, 0);
    chk("f_err_tied", err, 0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    force_ru = 1'b0;
    step;
    chk("f_busy_after", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
